// File: rtl/mul_issue_arbiter_pkg.sv
// Shared types and modulo sequence-number age helpers for shared-unit issue arbiters.
package mul_issue_arbiter_pkg;

  localparam int SQN_W_DEF = 6;

  typedef logic [SQN_W_DEF-1:0] SqN_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Operands are zero-extended; shifting left by (32-w) keeps only the w-bit modulo difference in the MSBs.
  function automatic logic sqn_younger(input logic [31:0] a, input logic [31:0] b,
                                       input int unsigned w);
    logic [31:0] d;
    d = (a - b) << (32 - w);
    return $signed(d) > 32'sd0;
  endfunction

  function automatic logic sqn_older(input logic [31:0] a, input logic [31:0] b,
                                     input int unsigned w);
    logic [31:0] d;
    d = (a - b) << (32 - w);
    return $signed(d) < 32'sd0;
  endfunction

endpackage

// File: rtl/mul_issue_arbiter_age_select.sv
// Combinational oldest-first selector: one-hot grant of the valid entry with the oldest sqN.
module age_select
  import mul_issue_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int SQN_W     = 6
) (
  input  logic [NUM_PORTS-1:0]       valid,
  input  logic [NUM_PORTS*SQN_W-1:0] sqn,
  output logic [NUM_PORTS-1:0]       grant
);

  logic             found;
  logic [SQN_W-1:0] best;
  logic [SQN_W-1:0] cur;

  // Linear scan with strict "older" keeps the result one-hot and favours the lowest port on ties.
  always_comb begin
    grant = '0;
    found = 1'b0;
    best  = '0;
    cur   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      cur = sqn[p*SQN_W +: SQN_W];
      if (valid[p] && (!found || sqn_older(32'(cur), 32'(best), SQN_W))) begin
        grant    = '0;
        grant[p] = 1'b1;
        best     = cur;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_issue_arbiter.sv
// Shares one iterative multiplier between issue ports: per-port holding slots, oldest-first grant,
// single in-flight tracking and branch flush of slots, incoming uops and the in-flight op.
module mul_issue_arbiter
  import mul_issue_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int SQN_W     = 6,
  parameter int PAYLOAD_W = 165
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           IN_branch_taken,
  input  logic [SQN_W-1:0]               IN_branch_sqN,
  input  logic [NUM_PORTS-1:0]           IN_valid,
  input  logic [NUM_PORTS*SQN_W-1:0]     IN_sqN,
  input  logic [NUM_PORTS*PAYLOAD_W-1:0] IN_payload,
  output logic [NUM_PORTS-1:0]           OUT_ready,
  output logic                           OUT_unit_valid,
  output logic [SQN_W-1:0]               OUT_unit_sqN,
  output logic [PAYLOAD_W-1:0]           OUT_unit_payload,
  input  logic                           IN_unit_busy,
  input  logic                           IN_unit_done
);

  logic [NUM_PORTS-1:0]       slot_v;
  logic [SQN_W-1:0]           slot_sqn [NUM_PORTS];
  logic [PAYLOAD_W-1:0]       slot_pl  [NUM_PORTS];
  logic [NUM_PORTS-1:0]       slot_flush, elig, raw_grant, grant, ready, accept;
  logic [NUM_PORTS*SQN_W-1:0] slot_sqn_flat;
  logic [SQN_W-1:0]           in_sqn;
  state_t                     state, state_next;
  logic [SQN_W-1:0]           inflight_sqn;
  logic                       inflight_flush, unit_free;
  logic [SQN_W-1:0]           sel_sqn;
  logic [PAYLOAD_W-1:0]       sel_pl;

  always_comb begin
    slot_flush    = '0;
    elig          = '0;
    slot_sqn_flat = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      slot_flush[p] = slot_v[p] && IN_branch_taken &&
                      sqn_younger(32'(slot_sqn[p]), 32'(IN_branch_sqN), SQN_W);
      elig[p]       = slot_v[p] && !slot_flush[p];
      slot_sqn_flat[p*SQN_W +: SQN_W] = slot_sqn[p];
    end
  end

  age_select #(
    .NUM_PORTS(NUM_PORTS),
    .SQN_W    (SQN_W)
  ) u_age_select (
    .valid(elig),
    .sqn  (slot_sqn_flat),
    .grant(raw_grant)
  );

  // A completing or flushed in-flight op frees the unit for a grant in the same cycle.
  assign inflight_flush = (state == BUSY) && IN_branch_taken &&
                          sqn_younger(32'(inflight_sqn), 32'(IN_branch_sqN), SQN_W);
  assign unit_free      = !IN_unit_busy && ((state == IDLE) || IN_unit_done || inflight_flush);
  assign grant          = unit_free ? raw_grant : '0;

  always_comb begin
    ready  = '0;
    accept = '0;
    in_sqn = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_sqn    = IN_sqN[p*SQN_W +: SQN_W];
      ready[p]  = !rst && (!slot_v[p] || grant[p]);
      accept[p] = IN_valid[p] && ready[p] &&
                  !(IN_branch_taken && sqn_younger(32'(in_sqn), 32'(IN_branch_sqN), SQN_W));
    end
  end

  assign OUT_ready = ready;

  always_comb begin
    sel_sqn = '0;
    sel_pl  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel_sqn = slot_sqn[p];
        sel_pl  = slot_pl[p];
      end
    end
  end

  always_comb begin
    state_next = state;
    if (|grant) begin
      state_next = BUSY;
    end else if ((state == BUSY) && (IN_unit_done || inflight_flush)) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Slot stage: a granted or flushed slot empties; a same-cycle accept refills it.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rst) begin
        slot_v[p] <= 1'b0;
      end else if (accept[p]) begin
        slot_v[p] <= 1'b1;
      end else if (grant[p] || slot_flush[p]) begin
        slot_v[p] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (accept[p]) begin
        slot_sqn[p] <= IN_sqN[p*SQN_W +: SQN_W];
        slot_pl[p]  <= IN_payload[p*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (|grant) begin
      inflight_sqn <= sel_sqn;
    end
  end

  // Issue stage: one-cycle strobe carrying the granted uop to the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_unit_valid   <= 1'b0;
      OUT_unit_sqN     <= '0;
      OUT_unit_payload <= '0;
    end else begin
      OUT_unit_valid <= |grant;
      if (|grant) begin
        OUT_unit_sqN     <= sel_sqn;
        OUT_unit_payload <= sel_pl;
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_arbiter.sv
// Scoreboard bench for mul_issue_arbiter: directed stimulus queues expected issues, a monitor checks them.
module tb_mul_issue_arbiter;

  localparam int NP = 2;
  localparam int SW = 6;
  localparam int PW = 165;

  logic             clk;
  logic             rst;
  logic             IN_branch_taken;
  logic [SW-1:0]    IN_branch_sqN;
  logic [NP-1:0]    IN_valid;
  logic [NP*SW-1:0] IN_sqN;
  logic [NP*PW-1:0] IN_payload;
  logic [NP-1:0]    OUT_ready;
  logic             OUT_unit_valid;
  logic [SW-1:0]    OUT_unit_sqN;
  logic [PW-1:0]    OUT_unit_payload;
  logic             IN_unit_busy;
  logic             IN_unit_done;

  mul_issue_arbiter #(
    .NUM_PORTS(NP),
    .SQN_W    (SW),
    .PAYLOAD_W(PW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .IN_branch_taken (IN_branch_taken),
    .IN_branch_sqN   (IN_branch_sqN),
    .IN_valid        (IN_valid),
    .IN_sqN          (IN_sqN),
    .IN_payload      (IN_payload),
    .OUT_ready       (OUT_ready),
    .OUT_unit_valid  (OUT_unit_valid),
    .OUT_unit_sqN    (OUT_unit_sqN),
    .OUT_unit_payload(OUT_unit_payload),
    .IN_unit_busy    (IN_unit_busy),
    .IN_unit_done    (IN_unit_done)
  );

  typedef struct {
    int sqn;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   c;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] pl(input int s);
    logic [7:0] b;
    b = s[7:0];
    return {b, 149'h0, b ^ 8'hA5};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NP-1:0] v, input int s0, input int s1);
    IN_valid   = v;
    IN_sqN     = {6'(s1), 6'(s0)};
    IN_payload = {pl(s1), pl(s0)};
  endtask

  task automatic idle_in();
    IN_valid = '0;
  endtask

  task automatic expect_issue(input int s, input int at);
    exp_t e;
    e.sqn = s;
    e.cyc = at;
    q.push_back(e);
  endtask

  task automatic free_unit();
    IN_unit_done = 1'b1;
    tick();
    IN_unit_done = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (OUT_unit_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got sqN %0d required no issue (cycle %0d)", OUT_unit_sqN, cyc);
      end else begin
        e = q.pop_front();
        check("issue_sqn", 64'(OUT_unit_sqN), 64'(e.sqn));
        check("issue_cycle", 64'(cyc), 64'(e.cyc));
        checks++;
        if (OUT_unit_payload !== pl(e.sqn)) begin
          errors++;
          $display("FAIL issue_payload: got %0h expected %0h", OUT_unit_payload, pl(e.sqn));
        end
      end
    end
  end

  initial begin
    rst             = 1'b1;
    IN_branch_taken = 1'b0;
    IN_branch_sqN   = '0;
    IN_valid        = '0;
    IN_sqN          = '0;
    IN_payload      = '0;
    IN_unit_busy    = 1'b0;
    IN_unit_done    = 1'b0;
    tick();
    tick();
    check("rst_ready", 64'(OUT_ready), 64'(2'b00));
    check("rst_valid", 64'(OUT_unit_valid), 64'(1'b0));
    check("rst_sqn", 64'(OUT_unit_sqN), 64'(0));
    rst = 1'b0;
    tick();
    check("idle_ready", 64'(OUT_ready), 64'(2'b11));

    // single uop, then a second one waits for done
    c = cyc;
    drive(2'b01, 5, 0);
    expect_issue(5, c + 2);
    tick();
    check("t1_ready_grant", 64'(OUT_ready), 64'(2'b11));
    idle_in();
    tick();
    tick();
    drive(2'b10, 0, 7);
    tick();
    check("t1_ready_held", 64'(OUT_ready), 64'(2'b01));
    idle_in();
    tick();
    IN_unit_done = 1'b1;
    expect_issue(7, c + 6);
    tick();
    IN_unit_done = 1'b0;
    tick();
    free_unit();

    // age order
    c = cyc;
    drive(2'b11, 12, 10);
    expect_issue(10, c + 2);
    tick();
    idle_in();
    tick();
    tick();
    IN_unit_done = 1'b1;
    expect_issue(12, c + 4);
    tick();
    IN_unit_done = 1'b0;
    tick();
    free_unit();

    // wrap-around: 62 is older than 1
    c = cyc;
    drive(2'b11, 62, 1);
    expect_issue(62, c + 2);
    tick();
    idle_in();
    tick();
    tick();
    IN_unit_done = 1'b1;
    expect_issue(1, c + 4);
    tick();
    IN_unit_done = 1'b0;
    tick();
    free_unit();

    // slot flush while the unit reports busy
    c = cyc;
    IN_unit_busy = 1'b1;
    drive(2'b11, 20, 25);
    tick();
    check("t4_ready_full", 64'(OUT_ready), 64'(2'b00));
    idle_in();
    IN_branch_taken = 1'b1;
    IN_branch_sqN   = 6'd22;
    tick();
    check("t4_ready_freed", 64'(OUT_ready), 64'(2'b10));
    IN_branch_taken = 1'b0;
    IN_unit_busy    = 1'b0;
    expect_issue(20, c + 3);
    tick();
    tick();
    free_unit();

    // in-flight flush frees the unit for an older waiting uop
    c = cyc;
    drive(2'b01, 30, 0);
    expect_issue(30, c + 2);
    tick();
    drive(2'b10, 0, 27);
    tick();
    idle_in();
    IN_branch_taken = 1'b1;
    IN_branch_sqN   = 6'd28;
    expect_issue(27, c + 3);
    tick();
    IN_branch_taken = 1'b0;
    tick();
    free_unit();

    // reset mid-flight with both slots full
    c = cyc;
    drive(2'b01, 40, 0);
    expect_issue(40, c + 2);
    tick();
    drive(2'b11, 41, 42);
    tick();
    idle_in();
    rst = 1'b1;
    tick();
    check("t6_ready_in_rst", 64'(OUT_ready), 64'(2'b00));
    check("t6_valid_in_rst", 64'(OUT_unit_valid), 64'(1'b0));
    rst = 1'b0;
    tick();
    check("t6_ready_after_rst", 64'(OUT_ready), 64'(2'b11));
    c = cyc;
    drive(2'b10, 0, 50);
    expect_issue(50, c + 2);
    tick();
    idle_in();
    tick();
    tick();
    free_unit();

    // younger incoming uop is consumed and dropped; older one is accepted
    c = cyc;
    IN_branch_taken = 1'b1;
    IN_branch_sqN   = 6'd60;
    drive(2'b11, 61, 59);
    expect_issue(59, c + 2);
    tick();
    check("t7_ready_drop", 64'(OUT_ready), 64'(2'b11));
    idle_in();
    IN_branch_taken = 1'b0;
    tick();
    tick();
    free_unit();

    tick();
    tick();
    tick();
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
